// File: rtl/sram_mem_responder.sv
// sram_mem_responder: serves 32-bit loads/stores as two 16-bit half-word
// transfers over an asynchronous SRAM, holding ready low while busy.
module sram_mem_responder #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [16:0] eff_q, eff_d;
    logic [31:0] rdata_q, rdata_d;
    logic        last, busy, drive;

    assign last = cnt_q == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            eff_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            eff_q   <= eff_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        eff_d   = eff_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (wr_en || rd_en) begin
                state_d = LOW;
                wr_d    = wr_en;
                // only the word index within the 256K half-word space is kept
                eff_d   = 17'((address - BASE_ADDR) >> 2);
                cnt_d   = '0;
            end
            LOW, HIGH: begin
                cnt_d = last ? '0 : cnt_q + 4'd1;
                if (last) begin
                    state_d = (state_q == LOW) ? HIGH : DONE;
                    if (!wr_q && state_q == LOW) rdata_d[15:0] = sram_dq_in;
                    if (!wr_q && state_q == HIGH) rdata_d[31:16] = sram_dq_in;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == LOW) || (state_q == HIGH);
    assign drive       = busy && wr_q;
    assign sram_addr   = busy ? {eff_q, state_q == HIGH} : '0;
    assign sram_dq_out = drive ? ((state_q == HIGH) ? write_data[31:16] : write_data[15:0]) : '0;
    assign sram_dq_oe  = drive;
    assign sram_we_n   = ~drive;
    assign ready       = ((state_q == IDLE) && !rd_en && !wr_en) || (state_q == DONE);
    assign read_data   = rdata_q;
endmodule

// File: tb/tb_sram_mem_responder.sv
// tb_sram_mem_responder: randomized and directed checks of the SRAM responder
// against a word-level reference memory and a behavioural SRAM model.
module tb_sram_mem_responder;
    localparam int          AC   = 2;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          LAT  = 2 * AC + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        pl_en = 1'b0;
    logic [17:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic [15:0] sram [0:262143];
    logic [15:0] ref_mem [int];
    logic [31:0] exp_rd;
    int          checks = 0, failures = 0;

    sram_mem_responder #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_in = sram[sram_addr];
    always @(posedge clk) begin
        if (pl_en) sram[pl_addr] <= pl_data;
        else if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
    end

    function automatic int hw_of(input logic [31:0] a);
        logic [31:0] e;
        e = a - BASE;
        return int'((e >> 2) % 32'd131072) * 2;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        int hw;
        hw = hw_of(a);
        ref_mem[hw] = d[15:0];
        ref_mem[hw + 1] = d[31:16];
        @(negedge clk); pl_en = 1'b1; pl_addr = 18'(hw); pl_data = d[15:0];
        @(negedge clk); pl_addr = 18'(hw + 1); pl_data = d[31:16];
        @(negedge clk); pl_en = 1'b0;
    endtask

    // Presents one request and observes it until ready; the request stays asserted on return.
    task automatic run_access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                              output int lat, output int seq_err, output logic early_ready);
        int hw;
        int half;
        hw = hw_of(a);
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; write_data = d;
        #1 early_ready = ready;
        lat = 0;
        seq_err = 0;
        while (lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ready) begin
                if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) seq_err++;
                break;
            end
            half = (lat > AC) ? 1 : 0;
            if (sram_addr !== 18'(hw + half)) seq_err++;
            if (w) begin
                if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 ||
                    sram_dq_out !== (half == 1 ? d[31:16] : d[15:0])) seq_err++;
            end else if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) seq_err++;
        end
        if (w) begin
            ref_mem[hw] = d[15:0];
            ref_mem[hw + 1] = d[31:16];
        end else if (r) exp_rd = {ref_mem[hw + 1], ref_mem[hw]};
    endtask

    task automatic release_req();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || read_data !== 32'h0 || sram_addr !== 18'h0) begin
            failures++;
            $display("FAIL reset: ready=%b we_n=%b oe=%b rd=%h addr=%h required 1 1 0 00000000 00000", ready, sram_we_n, sram_dq_oe, read_data, sram_addr);
        end
        rst_n = 1'b1;
        exp_rd = '0;
    endtask

    task automatic test_store();
        int lat, se;
        logic er;
        run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat, se, er);
        release_req();
        checks++;
        if (er !== 1'b0) begin failures++; $display("FAIL store_ready_drop: ready=%b required 0", er); end
        checks++;
        if (se != 0) begin failures++; $display("FAIL store_seq: errors=%0d required 0", se); end
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL store_latency: got %0d required %0d", lat, LAT); end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || {sram[1], sram[0]} !== 32'hDEADBEEF || read_data !== exp_rd) begin
            failures++;
            $display("FAIL store_after: ready=%b mem=%h rd=%h required 1 deadbeef %h", ready, {sram[1], sram[0]}, read_data, exp_rd);
        end
    endtask

    task automatic test_load();
        int lat, se;
        logic er;
        preload(32'd1028, 32'h12345678);
        run_access(1'b0, 1'b1, 32'd1028, $urandom, lat, se, er);
        release_req();
        checks++;
        if (se != 0 || er !== 1'b0) begin failures++; $display("FAIL load_seq: errors=%0d early_ready=%b required 0 0", se, er); end
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL load_latency: got %0d required %0d", lat, LAT); end
        checks++;
        if (read_data !== 32'h12345678 || read_data !== exp_rd) begin
            failures++;
            $display("FAIL load_data: got %h required 12345678", read_data);
        end
    endtask

    task automatic test_simultaneous();
        int lat, se;
        logic er;
        run_access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, lat, se, er);
        release_req();
        checks++;
        if (se != 0 || lat != LAT) begin failures++; $display("FAIL simul_write: errors=%0d lat=%0d required 0 %0d", se, lat, LAT); end
        checks++;
        if (read_data !== exp_rd || {sram[5], sram[4]} !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL simul_state: rd=%h mem=%h required %h cafef00d", read_data, {sram[5], sram[4]}, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, se1, se2, busy;
        logic er1, er2;
        preload(32'd2048, 32'hA1B2C3D4);
        preload(32'd2052, 32'h0F1E2D3C);
        run_access(1'b0, 1'b1, 32'd2048, 32'h0, lat1, se1, er1);
        checks++;
        if (read_data !== exp_rd || lat1 != LAT) begin failures++; $display("FAIL b2b_first: rd=%h lat=%0d required %h %0d", read_data, lat1, exp_rd, LAT); end
        run_access(1'b0, 1'b1, 32'd2052, 32'h0, lat2, se2, er2);
        release_req();
        checks++;
        if (er2 !== 1'b0 || lat2 != LAT || se1 + se2 != 0) begin
            failures++;
            $display("FAIL b2b_second: idle_ready=%b lat=%0d errors=%0d required 0 %0d 0", er2, lat2, se1 + se2, LAT);
        end
        checks++;
        if (read_data !== exp_rd) begin failures++; $display("FAIL b2b_data: got %h required %h", read_data, exp_rd); end
        busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready !== 1'b1 || sram_addr !== 18'h0) busy++;
        end
        checks++;
        if (busy != 0) begin failures++; $display("FAIL b2b_extra_access: busy_cycles=%0d required 0", busy); end
    endtask

    task automatic test_random();
        int lat, se, hw, bad;
        logic er, w, r;
        logic [31:0] a, d;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom % 2);
            r = w ? 1'($urandom % 2) : 1'b1;
            a = (i % 4 == 3) ? $urandom : BASE + ($urandom_range(0, 255) << 2) + ($urandom % 4);
            d = $urandom;
            hw = hw_of(a);
            if (!w) preload(a, $urandom);
            run_access(w, r, a, d, lat, se, er);
            release_req();
            checks++;
            if (se != 0 || er !== 1'b0 || lat != LAT || read_data !== exp_rd ||
                (w && {sram[hw + 1], sram[hw]} !== {ref_mem[hw + 1], ref_mem[hw]})) begin
                failures++;
                $display("FAIL random_%0d: w=%b a=%h lat=%0d errors=%0d rd=%h required lat %0d rd %h", i, w, a, lat, se, read_data, LAT, exp_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1040; write_data = 32'h55AA33CC;
        repeat (AC + 1) @(negedge clk);
        checks++;
        if (sram_addr !== 18'd9 || sram_we_n !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_high: addr=%h we_n=%b required 00009 0", sram_addr, sram_we_n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'h0 || read_data !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset: we_n=%b oe=%b addr=%h rd=%h required 1 0 00000 00000000", sram_we_n, sram_dq_oe, sram_addr, read_data);
        end
        release_req();
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL mid_after_release: bad_cycles=%0d required 0", bad); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
